// File: rtl/neuron_writeback.sv
// rtl/neuron_writeback.sv - rescale/activate accumulator results, buffer and write back to neuron RAM
// Optional ReLU with unsigned saturation when WB_RELU_EN is defined; signed saturation otherwise.
module neuron_writeback #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 16,
  parameter int ADDR_W     = 8,
  parameter int FRAC_BITS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              layer_start,
  input  logic [ADDR_W-1:0] write_base,
  input  logic [7:0]        layer_size,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              acc_valid,
  output logic              acc_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              ram_ready,
  output logic              layer_done,
  output logic              busy,
  output logic              protocol_err
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [7:0]        size_q;
  logic [7:0]        accepted;
  logic [7:0]        written;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;

  logic signed [ACC_W-1:0] shifted;
  logic [DATA_W-1:0]       act_val;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign acc_ready  = (state == ACTIVE) && !fifo_full && (accepted < size_q);
  assign wr_en      = (state == ACTIVE) && !fifo_empty;
  assign push       = acc_valid && acc_ready;
  assign pop        = wr_en && ram_ready;

  assign wr_addr    = wr_en ? (base_q + ADDR_W'(written)) : '0;
  assign wr_data    = wr_en ? fifo_mem[rd_ptr[PW-1:0]] : '0;
  assign layer_done = (state == DONE);
  assign busy       = (state != IDLE);

  assign shifted = $signed(acc_in) >>> FRAC_BITS;

`ifdef WB_RELU_EN
  localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((1 << DATA_W) - 1);

  always_comb begin
    act_val = shifted[DATA_W-1:0];
    if (shifted < 0)
      act_val = '0;
    else if (shifted > U_MAX)
      act_val = '1;
  end
`else
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

  always_comb begin
    act_val = shifted[DATA_W-1:0];
    if (shifted > S_MAX)
      act_val = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < S_MIN)
      act_val = {1'b1, {(DATA_W-1){1'b0}}};
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (layer_start)
          state_nxt = (layer_size == 8'd0) ? DONE : ACTIVE;
      end
      ACTIVE: begin
        if (pop && (written + 8'd1 == size_q))
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      base_q       <= '0;
      size_q       <= '0;
      accepted     <= '0;
      written      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && layer_start) begin
        base_q   <= write_base;
        size_q   <= layer_size;
        accepted <= '0;
        written  <= '0;
      end
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        accepted <= accepted + 8'd1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        written <= written + 8'd1;
      end
      // Extra results past the layer size and restarts mid-layer are both sticky faults.
      if ((layer_start && state != IDLE) ||
          (acc_valid && state == ACTIVE && accepted == size_q))
        protocol_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr[PW-1:0]] <= act_val;
  end

endmodule

// File: tb/tb_neuron_writeback.sv
// tb/tb_neuron_writeback.sv - table/scoreboard bench for neuron_writeback
module tb_neuron_writeback;

  logic       clk = 1'b0;
  logic       reset;
  logic       layer_start;
  logic [7:0] write_base;
  logic [7:0] layer_size;
  logic [15:0] acc_in;
  logic       acc_valid;
  logic       acc_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       ram_ready;
  logic       layer_done;
  logic       busy;
  logic       protocol_err;

  neuron_writeback dut (
    .clk(clk), .reset(reset), .layer_start(layer_start), .write_base(write_base),
    .layer_size(layer_size), .acc_in(acc_in), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ram_ready(ram_ready),
    .layer_done(layer_done), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] acc; logic [7:0] exp_sat; logic [7:0] exp_relu; } vec_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;

  vec_t vecs [8];
  wr_t  exp_q [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_wr_cyc = 0;
  int done_cnt = 0;
  bit chk_done_lat = 1'b1;
  logic [7:0] tb_base;
  logic [7:0] tb_idx;

  logic       prev_stall = 1'b0;
  logic       prev_reset = 1'b1;
  logic       prev_done  = 1'b0;
  logic [7:0] prev_addr, prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_of(input vec_t v);
`ifdef WB_RELU_EN
    return v.exp_relu;
`else
    return v.exp_sat;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pops an expected write for every completed RAM write.
  always @(negedge clk) begin
    wr_t w;
    if (prev_stall && !prev_reset) begin
      check("hold_wr_en", wr_en, 1);
      check("hold_wr_addr", wr_addr, prev_addr);
      check("hold_wr_data", wr_data, prev_data);
    end
    if (wr_en && ram_ready && !reset) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", wr_addr, w.addr);
        check("wr_data", wr_data, w.data);
      end
      last_wr_cyc = cyc;
    end
    if (layer_done) begin
      done_cnt++;
      check("done_width", prev_done, 0);
      if (chk_done_lat) check("done_latency", cyc - last_wr_cyc, 1);
    end
    prev_done  = layer_done;
    prev_stall = wr_en && !ram_ready && !reset;
    prev_reset = reset;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
  end

  task automatic start_layer(input logic [7:0] base, input logic [7:0] size);
    layer_start = 1'b1;
    write_base  = base;
    layer_size  = size;
    tb_base     = base;
    tb_idx      = 8'd0;
    @(posedge clk); #1;
    layer_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] e);
    bit  ok = 1'b0;
    wr_t w;
    acc_valid = 1'b1;
    acc_in    = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_ready) begin
        w.addr = tb_base + tb_idx;
        w.data = e;
        exp_q.push_back(w);
        tb_idx = tb_idx + 8'd1;
        ok = 1'b1;
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    acc_valid = 1'b0;
    check("accept", ok, 1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (layer_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("layer_done_seen", seen, 1);
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_layer_done", layer_done, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acc_ready"}, acc_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_layer_done"}, layer_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_protocol_err"}, protocol_err, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0130, 8'h13, 8'h13};
    vecs[1] = '{16'h0050, 8'h05, 8'h05};
    vecs[2] = '{16'h0000, 8'h00, 8'h00};
    vecs[3] = '{16'hFFE0, 8'hFE, 8'h00};
    vecs[4] = '{16'h2000, 8'h7F, 8'hFF};
    vecs[5] = '{16'hE000, 8'h80, 8'h00};
    vecs[6] = '{16'h0FF0, 8'h7F, 8'hFF};
    vecs[7] = '{16'hFFFF, 8'hFF, 8'h00};

    reset = 1'b1; layer_start = 1'b0; write_base = '0; layer_size = '0;
    acc_in = '0; acc_valid = 1'b0; ram_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all_zero("reset");

    // Basic layer with first-write latency check.
    start_layer(8'h10, 8'd3);
    send(vecs[0].acc, exp_of(vecs[0]));
    check("latency_wr_en", wr_en, 1);
    check("latency_wr_addr", wr_addr, 8'h10);
    for (int i = 1; i < 3; i++) send(vecs[i].acc, exp_of(vecs[i]));
    wait_done();

    // Activation table and address wrap.
    start_layer(8'hFE, 8'd5);
    for (int i = 3; i < 8; i++) send(vecs[i].acc, exp_of(vecs[i]));
    wait_done();

    // Backpressure: RAM stalled, FIFO fills to 4.
    ram_ready = 1'b0;
    start_layer(8'h40, 8'd6);
    fork
      for (int k = 0; k < 6; k++) send(16'((k + 1) * 16 + 3), 8'(k + 1));
      begin
        repeat (8) @(negedge clk);
        check("bp_accepted", tb_idx, 4);
        check("bp_acc_ready", acc_ready, 0);
        check("bp_wr_en", wr_en, 1);
        check("bp_wr_addr", wr_addr, 8'h40);
        @(posedge clk); #1;
        ram_ready = 1'b1;
      end
    join
    wait_done();

    // Overrun and mid-layer restart errors.
    ram_ready = 1'b0;
    start_layer(8'h60, 8'd2);
    send(16'h0010, 8'h01);
    send(16'h0020, 8'h02);
    check("err_before", protocol_err, 0);
    acc_valid = 1'b1; acc_in = 16'h0777;
    @(negedge clk);
    check("err_acc_ready", acc_ready, 0);
    @(posedge clk); #1;
    acc_valid = 1'b0;
    check("err_overrun", protocol_err, 1);
    layer_start = 1'b1; write_base = 8'h99; layer_size = 8'd5;
    @(posedge clk); #1;
    layer_start = 1'b0;
    check("err_restart_busy", busy, 1);
    check("err_restart_flag", protocol_err, 1);
    ram_ready = 1'b1;
    wait_done();
    check("err_sticky", protocol_err, 1);

    // Reset mid-layer with FIFO holding entries.
    ram_ready = 1'b0;
    start_layer(8'h80, 8'd3);
    for (int i = 0; i < 3; i++) send(vecs[i].acc, exp_of(vecs[i]));
    ram_ready = 1'b1;
    @(posedge clk); #1;
    ram_ready = 1'b0;
    check("mid_wr_addr", wr_addr, 8'h81);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    check_all_zero("midreset");

    ram_ready = 1'b1;
    start_layer(8'h20, 8'd2);
    send(vecs[0].acc, exp_of(vecs[0]));
    send(vecs[1].acc, exp_of(vecs[1]));
    wait_done();

    // Empty layer goes straight to DONE.
    chk_done_lat = 1'b0;
    start_layer(8'h30, 8'd0);
    check("size0_done", layer_done, 1);
    check("size0_wr_en", wr_en, 0);
    @(posedge clk); #1;
    check("size0_done_low", layer_done, 0);
    check("size0_busy", busy, 0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_cnt, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
